// File: rtl/mem_arb.sv
// Two-requester arbiter/sequencer for a simple-dual-port memory with bounded-burst ownership.
// Optional feature macro: MEM_ARB_BURST_EN (defined = BURST limit applies, undefined = locked ownership).
module mem_arb #(
   parameter int ADDRW = 10,
   parameter int DATAW = 8,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [ADDRW-1:0] a_addr,
   input  logic [DATAW-1:0] a_wdata,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [ADDRW-1:0] b_addr,
   input  logic [DATAW-1:0] b_wdata,
   output logic             a_gnt,
   output logic             b_gnt,
   output logic             a_rvalid,
   output logic             b_rvalid,
   output logic [DATAW-1:0] a_rdata,
   output logic [DATAW-1:0] b_rdata,
   output logic             mem_wr_en,
   output logic [ADDRW-1:0] mem_wr_addr,
   output logic [DATAW-1:0] mem_wr_data,
   output logic [ADDRW-1:0] mem_rd_addr,
   input  logic [DATAW-1:0] mem_rd_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } owner_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   owner_t             owner_r;
   owner_t             owner_nxt_s;
   logic               last_r;
   logic               win_a_s;
   logic               win_b_s;
   logic               gnt_a_s;
   logic               gnt_b_s;
   logic               burst_hit_s;
   logic               a_rvalid_r;
   logic               b_rvalid_r;
   logic [DATAW-1:0]   a_rdata_r;
   logic [DATAW-1:0]   b_rdata_r;

`ifdef MEM_ARB_BURST_EN
   localparam int CW = $clog2(BURST + 1);
   localparam logic [CW-1:0] BURST_C = CW'(BURST);
   logic [CW-1:0] cnt_r;
   logic          same_owner_s;

   assign burst_hit_s  = (cnt_r >= BURST_C);
   assign same_owner_s = (gnt_a_s && (owner_r == OWN_A)) || (gnt_b_s && (owner_r == OWN_B));

   // Beats granted to the current owner, saturating at BURST, restarting at 1 on a switch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (!(gnt_a_s || gnt_b_s)) begin
         cnt_r <= {CW{1'b0}};
      end else if (same_owner_s) begin
         cnt_r <= (cnt_r < BURST_C) ? (cnt_r + CW'(1)) : BURST_C;
      end else begin
         cnt_r <= CW'(1);
      end
   end
`else
   // Locked ownership: the holder is never pre-empted, so BURST has no effect
   localparam logic BURST_OK = (BURST >= 1);
   assign burst_hit_s = 1'b0 & BURST_OK;
`endif

   // Winner selection and next owner
   always_comb begin
      win_a_s = 1'b0;
      win_b_s = 1'b0;
      case (owner_r)
         IDLE: begin
            if (a_req && b_req) begin
               win_a_s = (last_r == SEL_B);
               win_b_s = (last_r == SEL_A);
            end else begin
               win_a_s = a_req;
               win_b_s = b_req;
            end
         end
         OWN_A: begin
            if (a_req && !(b_req && burst_hit_s)) begin
               win_a_s = 1'b1;
            end else begin
               win_b_s = b_req;
            end
         end
         OWN_B: begin
            if (b_req && !(a_req && burst_hit_s)) begin
               win_b_s = 1'b1;
            end else begin
               win_a_s = a_req;
            end
         end
         default: begin
            win_a_s = 1'b0;
            win_b_s = 1'b0;
         end
      endcase
      if (win_a_s) begin
         owner_nxt_s = OWN_A;
      end else if (win_b_s) begin
         owner_nxt_s = OWN_B;
      end else begin
         owner_nxt_s = IDLE;
      end
   end

   assign gnt_a_s = win_a_s & rst_n;
   assign gnt_b_s = win_b_s & rst_n;
   assign a_gnt   = gnt_a_s;
   assign b_gnt   = gnt_b_s;

   assign mem_wr_en   = (gnt_a_s && a_we) || (gnt_b_s && b_we);
   assign mem_wr_addr = gnt_b_s ? b_addr  : a_addr;
   assign mem_wr_data = gnt_b_s ? b_wdata : a_wdata;
   assign mem_rd_addr = gnt_b_s ? b_addr  : a_addr;

   // Ownership state and last-served requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_r <= IDLE;
         last_r  <= SEL_B;
      end else begin
         owner_r <= owner_nxt_s;
         if (gnt_a_s) begin
            last_r <= SEL_A;
         end else if (gnt_b_s) begin
            last_r <= SEL_B;
         end else begin
            last_r <= last_r;
         end
      end
   end

   // Read return: capture the asynchronous read data for the granted reader
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rvalid_r <= 1'b0;
         b_rvalid_r <= 1'b0;
         a_rdata_r  <= {DATAW{1'b0}};
         b_rdata_r  <= {DATAW{1'b0}};
      end else begin
         a_rvalid_r <= gnt_a_s && !a_we;
         b_rvalid_r <= gnt_b_s && !b_we;
         if (gnt_a_s && !a_we) begin
            a_rdata_r <= mem_rd_data;
         end
         if (gnt_b_s && !b_we) begin
            b_rdata_r <= mem_rd_data;
         end
      end
   end

   assign a_rvalid = a_rvalid_r;
   assign b_rvalid = b_rvalid_r;
   assign a_rdata  = a_rdata_r;
   assign b_rdata  = b_rdata_r;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arb;
   localparam int ADDRW = 10;
   localparam int DATAW = 8;
   localparam int BURST = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic a_req, a_we, b_req, b_we;
   logic [ADDRW-1:0] a_addr, b_addr;
   logic [DATAW-1:0] a_wdata, b_wdata;
   logic a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [DATAW-1:0] a_rdata, b_rdata;
   logic mem_wr_en;
   logic [ADDRW-1:0] mem_wr_addr, mem_rd_addr;
   logic [DATAW-1:0] mem_wr_data, mem_rd_data;

   mem_arb #(.ADDRW(ADDRW), .DATAW(DATAW), .BURST(BURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt),
      .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
      .a_rdata(a_rdata), .b_rdata(b_rdata),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   // The memory device itself
   logic [DATAW-1:0] mem [0:(1<<ADDRW)-1];
   always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
   assign mem_rd_data = mem[mem_rd_addr];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: 0 = nobody, 1 = A, 2 = B
   logic [DATAW-1:0] ref_mem [0:(1<<ADDRW)-1];
   int m_owner, m_run, m_last;
   logic exp_rv_a, exp_rv_b;
   logic [DATAW-1:0] exp_rd_a, exp_rd_b;
   logic prev_ga, prev_gb;

   task automatic model_reset();
      m_owner = 0; m_run = 0; m_last = 2;
      exp_rv_a = 1'b0; exp_rv_b = 1'b0;
      exp_rd_a = '0; exp_rd_b = '0;
      prev_ga = 1'b0; prev_gb = 1'b0;
   endtask

   function automatic int m_winner(input logic ra, input logic rb);
      int holder, other;
      logic rh, ro;
      if (m_owner == 0) begin
         if (ra && rb) return (m_last == 2) ? 1 : 2;
         if (ra) return 1;
         if (rb) return 2;
         return 0;
      end
      holder = m_owner;
      other  = 3 - holder;
      rh = (holder == 1) ? ra : rb;
      ro = (holder == 1) ? rb : ra;
      if (rh && ro) begin
`ifdef MEM_ARB_BURST_EN
         return (m_run < BURST) ? holder : other;
`else
         return holder;
`endif
      end
      if (rh) return holder;
      if (ro) return other;
      return 0;
   endfunction

   // Compare one cycle of DUT outputs with the model, then advance the model
   task automatic step();
      int w;
      logic exp_wr;
      logic [ADDRW-1:0] waddr;
      logic [DATAW-1:0] wdata;
      w = m_winner(a_req, b_req);
      exp_wr = (w == 1 && a_we) || (w == 2 && b_we);
      waddr  = (w == 2) ? b_addr : a_addr;
      wdata  = (w == 2) ? b_wdata : a_wdata;
      check("a_gnt", 32'(a_gnt), 32'(w == 1));
      check("b_gnt", 32'(b_gnt), 32'(w == 2));
      check("mem_wr_en", 32'(mem_wr_en), 32'(exp_wr));
      if (exp_wr) begin
         check("mem_wr_addr", 32'(mem_wr_addr), 32'(waddr));
         check("mem_wr_data", 32'(mem_wr_data), 32'(wdata));
      end else if (w != 0) begin
         check("mem_rd_addr", 32'(mem_rd_addr), 32'(waddr));
      end
      check("a_rvalid", 32'(a_rvalid), 32'(exp_rv_a));
      check("b_rvalid", 32'(b_rvalid), 32'(exp_rv_b));
      check("a_rdata", 32'(a_rdata), 32'(exp_rd_a));
      check("b_rdata", 32'(b_rdata), 32'(exp_rd_b));
      exp_rv_a = (w == 1) && !a_we;
      exp_rv_b = (w == 2) && !b_we;
      if (exp_rv_a) exp_rd_a = ref_mem[a_addr];
      if (exp_rv_b) exp_rd_b = ref_mem[b_addr];
      if (exp_wr) ref_mem[waddr] = wdata;
      if (w != 0) begin
         m_run   = (w == m_owner) ? m_run + 1 : 1;
         m_owner = w;
         m_last  = w;
      end else begin
         m_owner = 0;
         m_run   = 0;
      end
      prev_ga = (w == 1);
      prev_gb = (w == 2);
   endtask

   task automatic half();
      @(negedge clk);
      step();
   endtask

   task automatic fin();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic req, input logic we, input int addr, input int data);
      a_req = req; a_we = we; a_addr = ADDRW'(addr); a_wdata = DATAW'(data);
   endtask

   task automatic drive_b(input logic req, input logic we, input int addr, input int data);
      b_req = req; b_we = we; b_addr = ADDRW'(addr); b_wdata = DATAW'(data);
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDRW); i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      rst_n = 1'b0;
      drive_a(1'b1, 1'b1, 1, 1);
      drive_b(1'b1, 1'b1, 2, 2);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_gnt", 32'(a_gnt), 32'd0);
      check("rst_b_gnt", 32'(b_gnt), 32'd0);
      check("rst_wr_en", 32'(mem_wr_en), 32'd0);
      check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
      check("rst_a_rdata", 32'(a_rdata), 32'd0);
      check("rst_b_rdata", 32'(b_rdata), 32'd0);
      drive_a(1'b0, 1'b0, 0, 0);
      drive_b(1'b0, 1'b0, 0, 0);
      rst_n = 1'b1;

      // Write then read back through requester A
      drive_a(1'b1, 1'b1, 3, 8'h5A);
      half();
      check("t1_wr_gnt", 32'(a_gnt), 32'd1);
      check("t1_wr_en", 32'(mem_wr_en), 32'd1);
      fin();
      drive_a(1'b1, 1'b0, 3, 0);
      half();
      check("t1_rd_gnt", 32'(a_gnt), 32'd1);
      check("t1_rd_wr_en", 32'(mem_wr_en), 32'd0);
      fin();
      drive_a(1'b0, 1'b0, 0, 0);
      half();
      check("t1_rvalid", 32'(a_rvalid), 32'd1);
      check("t1_rdata", 32'(a_rdata), 32'h5A);
      fin();

      // Tie from idle after A was last served
      drive_a(1'b1, 1'b0, 4, 0);
      drive_b(1'b1, 1'b0, 5, 0);
      half();
      check("tie_after_a", 32'(b_gnt), 32'd1);
      fin();
      drive_a(1'b0, 1'b0, 0, 0);
      drive_b(1'b0, 1'b0, 0, 0);
      half();
      fin();

      // Both requesting continuously; B was last so A starts
      drive_a(1'b1, 1'b0, 3, 0);
      drive_b(1'b1, 1'b0, 5, 0);
      for (int i = 0; i < 12; i++) begin
         half();
`ifdef MEM_ARB_BURST_EN
         check("burst_seq", 32'(a_gnt), 32'(((i / BURST) % 2) == 0));
`else
         check("locked_seq", 32'(a_gnt), 32'd1);
`endif
         fin();
      end
      drive_a(1'b0, 1'b0, 0, 0);
      half();
      check("switch_no_bubble", 32'(b_gnt), 32'd1);
      fin();
      drive_b(1'b0, 1'b0, 0, 0);

      // Reset in the cycle after a granted read of a non-zero location
      drive_a(1'b1, 1'b0, 3, 0);
      half();
      fin();
      drive_a(1'b0, 1'b0, 0, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_a_rvalid", 32'(a_rvalid), 32'd0);
      check("midrst_a_rdata", 32'(a_rdata), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_a(1'b1, 1'b0, 6, 0);
      drive_b(1'b1, 1'b0, 7, 0);
      half();
      check("tie_after_reset", 32'(a_gnt), 32'd1);
      fin();

      // Random traffic, requests held until granted or occasionally withdrawn
      for (int c = 0; c < 3000; c++) begin
         if (!a_req || prev_ga) begin
            drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
         end else if ($urandom_range(0, 15) == 0) begin
            a_req = 1'b0;
         end
         if (!b_req || prev_gb) begin
            drive_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
         end else if ($urandom_range(0, 15) == 0) begin
            b_req = 1'b0;
         end
         half();
         fin();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
